hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage 16-bit CPU (IF, ID, EX, DM, WB).
- Detects register RAW hazards using an internal scoreboard of in-flight destination registers and stalls IF/ID while a hazard exists.
- Flushes wrong-path instructions when a branch or jump resolves as taken in DM.
- Sequences halt: drains the pipeline before asserting hlt, and counts stall cycles.

---
 rtl/hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage 16-bit CPU.
// Tracks in-flight destination registers (EX/DM/WB) to stall IF/ID on RAW
// hazards, flushes wrong-path work on a taken DM-stage redirect, drains the
// pipeline before halting, and counts stall cycles.
// Optional build macro: WB_RF_BYPASS_EN (write-before-read register file,
// WB slot excluded from hazard checks).
module hazard_ctrl #(
    parameter int unsigned R0_ZERO = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [3:0]       id_rs1,
    input  logic             id_rs1_used,
    input  logic [3:0]       id_rs2,
    input  logic             id_rs2_used,
    input  logic             id_we,
    input  logic [3:0]       id_dst,
    input  logic             id_hlt,
    input  logic             dm_redirect,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_bubble,
    output logic             flush_if_id,
    output logic             flush_ex_dm,
    output logic             hlt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_e;

    typedef struct packed {
        logic       v;
        logic [3:0] dst;
    } slot_t;

    localparam logic R0_SKIP = (R0_ZERO != 0);

`ifdef WB_RF_BYPASS_EN
    localparam logic CHK_WB = 1'b0;
`else
    localparam logic CHK_WB = 1'b1;
`endif

    state_e           state_q, state_d;
    slot_t            ex_q, ex_d;
    slot_t            dm_q, dm_d;
    slot_t            wb_q, wb_d;
    logic [1:0]       drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rs1_hz, rs2_hz, hazard, stall, issue, slots_empty;

    function automatic logic slot_hit(input slot_t s, input logic [3:0] r);
        return s.v && (s.dst == r);
    endfunction

    // RAW detection against the in-flight destination scoreboard
    always_comb begin
        rs1_hz = id_rs1_used && !(R0_SKIP && (id_rs1 == 4'd0)) &&
                 (slot_hit(ex_q, id_rs1) || slot_hit(dm_q, id_rs1) ||
                  (CHK_WB && slot_hit(wb_q, id_rs1)));
        rs2_hz = id_rs2_used && !(R0_SKIP && (id_rs2 == 4'd0)) &&
                 (slot_hit(ex_q, id_rs2) || slot_hit(dm_q, id_rs2) ||
                  (CHK_WB && slot_hit(wb_q, id_rs2)));
        hazard      = rs1_hz || rs2_hz;
        stall       = id_valid && hazard && (state_q == S_RUN);
        issue       = id_valid && (state_q == S_RUN) && !stall && !dm_redirect;
        slots_empty = !ex_q.v && !dm_q.v && !wb_q.v;
    end

    // Scoreboard advance and saturating stall counter
    always_comb begin
        ex_d.v   = issue && id_we && !(R0_SKIP && (id_dst == 4'd0));
        ex_d.dst = id_dst;
        dm_d     = dm_redirect ? '0 : ex_q;
        wb_d     = dm_q;
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Halt sequencing: next state and drain counter
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_RUN: begin
                drain_cnt_d = 2'd3;
                // The HLT acceptance cycle is the first drain count, so the
                // counter enters DRAIN already at 2 and DRAIN lasts 3 cycles.
                if (issue && id_hlt) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 2'd2;
                end
            end
            S_DRAIN: begin
                if (dm_redirect) begin
                    state_d     = S_RUN;
                    drain_cnt_d = 2'd3;
                end else if (drain_cnt_q == 2'd0) begin
                    if (slots_empty) begin
                        state_d = S_HALTED;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q - 2'd1;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d     = S_RUN;
                drain_cnt_d = 2'd3;
            end
        endcase
    end

    // Pipeline control outputs, forced to a safe idle while in reset
    always_comb begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_bubble = 1'b1;
        flush_if_id  = 1'b0;
        flush_ex_dm  = 1'b0;
        hlt          = 1'b0;
        if (rst_n) begin
            if (state_q == S_HALTED) begin
                hlt = 1'b1;
            end else if (dm_redirect) begin
                pc_we        = 1'b1;
                if_id_we     = 1'b1;
                id_ex_bubble = 1'b1;
                flush_if_id  = 1'b1;
                flush_ex_dm  = 1'b1;
            end else if ((state_q == S_RUN) && !stall) begin
                pc_we        = 1'b1;
                if_id_we     = 1'b1;
                id_ex_bubble = 1'b0;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;

    // State, scoreboard and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            ex_q        <= '0;
            dm_q        <= '0;
            wb_q        <= '0;
            drain_cnt_q <= 2'd3;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            dm_q        <= dm_d;
            wb_q        <= wb_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the stimulus process queues the expected
// control vector for each cycle; the monitor pops and compares on negedge.
module tb_hazard_ctrl;

  localparam int unsigned CW = 4;
`ifdef WB_RF_BYPASS_EN
  localparam int unsigned STL = 2;
`else
  localparam int unsigned STL = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [3:0]    id_rs1 = '0;
  logic          id_rs1_used = 1'b0;
  logic [3:0]    id_rs2 = '0;
  logic          id_rs2_used = 1'b0;
  logic          id_we = 1'b0;
  logic [3:0]    id_dst = '0;
  logic          id_hlt = 1'b0;
  logic          dm_redirect = 1'b0;
  logic          pc_we, if_id_we, id_ex_bubble, flush_if_id, flush_ex_dm, hlt;
  logic [CW-1:0] stall_cnt;
  logic          done = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .R0_ZERO(1),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs1_used (id_rs1_used),
    .id_rs2      (id_rs2),
    .id_rs2_used (id_rs2_used),
    .id_we       (id_we),
    .id_dst      (id_dst),
    .id_hlt      (id_hlt),
    .dm_redirect (dm_redirect),
    .pc_we       (pc_we),
    .if_id_we    (if_id_we),
    .id_ex_bubble(id_ex_bubble),
    .flush_if_id (flush_if_id),
    .flush_ex_dm (flush_ex_dm),
    .hlt         (hlt),
    .stall_cnt   (stall_cnt)
  );

  typedef enum int {K_NORM, K_STALL, K_RDR, K_DRAIN, K_HALT, K_RST} kind_e;

  // ctl = {pc_we, if_id_we, id_ex_bubble, flush_if_id, flush_ex_dm, hlt}
  typedef struct {
    logic [5:0]    ctl;
    logic [CW-1:0] cnt;
    string         name;
  } exp_t;

  exp_t          sbq[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic cyc(input logic rst, input logic v, input logic we, input logic [3:0] dst,
                     input logic u1, input logic [3:0] rs1, input logic u2, input logic [3:0] rs2,
                     input logic h, input logic rd, input kind_e k, input logic inc,
                     input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = rst;
    id_valid    = v;
    id_we       = we;
    id_dst      = dst;
    id_rs1_used = u1;
    id_rs1      = rs1;
    id_rs2_used = u2;
    id_rs2      = rs2;
    id_hlt      = h;
    dm_redirect = rd;
    case (k)
      K_NORM:  e.ctl = 6'b110000;
      K_STALL: e.ctl = 6'b001000;
      K_RDR:   e.ctl = 6'b111110;
      K_DRAIN: e.ctl = 6'b001000;
      K_HALT:  e.ctl = 6'b001001;
      K_RST:   e.ctl = 6'b001000;
      default: e.ctl = 6'b000000;
    endcase
    if (k == K_RST) exp_cnt = '0;
    e.cnt  = exp_cnt;
    e.name = nm;
    sbq.push_back(e);
    if (inc && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [5:0] act;
    if (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = {pc_we, if_id_we, id_ex_bubble, flush_if_id, flush_ex_dm, hlt};
      checks++;
      if ((act !== e.ctl) || (stall_cnt !== e.cnt)) begin
        errors++;
        $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 e.name, act, stall_cnt, e.ctl, e.cnt);
      end
    end
  end

  initial begin : watchdog
    #200000;
    if (!done) begin
      errors++;
      $display("FAIL timeout: stimulus did not complete within the expected wait");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    // reset and idle
    cyc(0, 0,0,4'd0, 0,4'd0, 0,4'd0, 0,0, K_RST,  0, "reset outputs");
    cyc(1, 0,0,4'd0, 0,4'd0, 0,4'd0, 0,0, K_NORM, 0, "idle after reset");

    // RAW: ADD R3 then immediate reader of R3
    cyc(1, 1,1,4'd3, 1,4'd1, 1,4'd2, 0,0, K_NORM, 0, "issue ADD R3");
    for (int unsigned i = 0; i < STL; i++)
      cyc(1, 1,1,4'd4, 1,4'd3, 0,4'd0, 0,0, K_STALL, 1, "RAW stall on R3");
    cyc(1, 1,1,4'd4, 1,4'd3, 0,4'd0, 0,0, K_NORM, 0, "RAW consumer issues");

    // R0 writes untracked, R0 reads never stall
    cyc(1, 1,1,4'd0, 0,4'd0, 0,4'd0, 0,0, K_NORM, 0, "write R0");
    cyc(1, 1,0,4'd0, 1,4'd0, 1,4'd0, 0,0, K_NORM, 0, "read R0 no stall");
    cyc(1, 0,0,4'd0, 0,4'd0, 0,4'd0, 0,0, K_NORM, 0, "idle");

    // redirect during a stall
    cyc(1, 1,1,4'd5, 0,4'd0, 0,4'd0, 0,0, K_NORM,  0, "issue ADD R5");
    cyc(1, 1,1,4'd7, 0,4'd0, 0,4'd0, 0,0, K_NORM,  0, "issue ADD R7");
    cyc(1, 1,1,4'd6, 1,4'd7, 0,4'd0, 0,0, K_STALL, 1, "stall on R7");
    cyc(1, 1,1,4'd6, 1,4'd7, 0,4'd0, 0,1, K_RDR,   1, "redirect during stall");
    if (STL == 3)
      cyc(1, 1,0,4'd0, 1,4'd7, 0,4'd0, 0,0, K_STALL, 1, "WB slot survives redirect");
    else
      cyc(1, 1,0,4'd0, 1,4'd7, 0,4'd0, 0,0, K_NORM,  0, "WB slot bypassed after redirect");
    cyc(1, 0,0,4'd0, 0,4'd0, 0,4'd0, 0,0, K_NORM, 0, "idle");

    // redirect kills the EX instruction and blocks ID issue
    cyc(1, 1,1,4'd8, 0,4'd0, 0,4'd0, 0,0, K_NORM, 0, "issue ADD R8");
    cyc(1, 1,1,4'd9, 0,4'd0, 0,4'd0, 0,1, K_RDR,  0, "redirect kills EX");
    cyc(1, 1,0,4'd0, 1,4'd8, 1,4'd9, 0,0, K_NORM, 0, "no stall on flushed regs");

    // halt drain with a producer still in flight
    cyc(1, 1,1,4'd10, 0,4'd0, 0,4'd0, 0,0, K_NORM, 0, "issue ADD R10");
    cyc(1, 1,0,4'd0,  0,4'd0, 0,4'd0, 1,0, K_NORM, 0, "HLT accepted");
    cyc(1, 1,1,4'd11, 1,4'd10, 0,4'd0, 0,0, K_DRAIN, 0, "drain cycle 1");
    cyc(1, 1,1,4'd11, 1,4'd10, 0,4'd0, 0,0, K_DRAIN, 0, "drain cycle 2");
    cyc(1, 1,1,4'd11, 1,4'd10, 0,4'd0, 0,0, K_DRAIN, 0, "drain cycle 3");
    for (int unsigned i = 0; i < 3; i++)
      cyc(1, 1,1,4'd11, 1,4'd10, 0,4'd0, 0,0, K_HALT, 0, "halted");

    // reset out of HALTED, then HLT cancelled by an older redirect
    cyc(0, 0,0,4'd0, 0,4'd0, 0,4'd0, 0,0, K_RST,  0, "async reset from halted");
    cyc(1, 0,0,4'd0, 0,4'd0, 0,4'd0, 0,0, K_NORM, 0, "run after reset");
    cyc(1, 1,0,4'd0, 0,4'd0, 0,4'd0, 1,0, K_NORM, 0, "HLT accepted (wrong path)");
    cyc(1, 0,0,4'd0, 0,4'd0, 0,4'd0, 0,1, K_RDR,  0, "redirect cancels drain");
    for (int unsigned i = 0; i < 3; i++)
      cyc(1, 0,0,4'd0, 0,4'd0, 0,4'd0, 0,0, K_NORM, 0, "running after cancelled halt");

    // a fresh HLT drains the full 3 cycles again
    cyc(1, 1,0,4'd0, 0,4'd0, 0,4'd0, 1,0, K_NORM, 0, "HLT accepted again");
    for (int unsigned i = 0; i < 3; i++)
      cyc(1, 0,0,4'd0, 0,4'd0, 0,4'd0, 0,0, K_DRAIN, 0, "drain after cancel");
    cyc(1, 0,0,4'd0, 0,4'd0, 0,4'd0, 0,0, K_HALT, 0, "halted after drain");
    cyc(0, 0,0,4'd0, 0,4'd0, 0,4'd0, 0,0, K_RST,  0, "reset from halted again");

    // reset pulled mid-stall
    cyc(1, 1,1,4'd11, 0,4'd0,  0,4'd0, 0,0, K_NORM,  0, "issue ADD R11");
    cyc(1, 1,1,4'd12, 1,4'd11, 0,4'd0, 0,0, K_STALL, 1, "stall on R11");
    cyc(0, 1,1,4'd12, 1,4'd11, 0,4'd0, 0,0, K_RST,   0, "async reset mid-stall");
    #1;
    checks++;
    if ((hlt !== 1'b0) || (stall_cnt !== '0) || (pc_we !== 1'b0) || (if_id_we !== 1'b0) ||
        (id_ex_bubble !== 1'b1) || (flush_if_id !== 1'b0) || (flush_ex_dm !== 1'b0)) begin
      errors++;
      $display("FAIL reset state: hlt=%b cnt=%0d pc_we=%b if_id_we=%b bubble=%b flush=%b%b",
               hlt, stall_cnt, pc_we, if_id_we, id_ex_bubble, flush_if_id, flush_ex_dm);
    end
    cyc(1, 1,0,4'd0,  1,4'd11, 0,4'd0, 0,0, K_NORM,  0, "issue after reset");

    // dependent chain on R12 to saturate the 4-bit stall counter
    for (int unsigned n = 0; n < 11; n++) begin
      cyc(1, 1,1,4'd12, 1,4'd12, 0,4'd0, 0,0, K_NORM, 0, "chain issue");
      for (int unsigned i = 0; i < STL; i++)
        cyc(1, 1,1,4'd12, 1,4'd12, 0,4'd0, 0,0, K_STALL, 1, "chain stall");
    end
    cyc(1, 0,0,4'd0, 0,4'd0, 0,4'd0, 0,0, K_NORM, 0, "stall_cnt saturated");

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (stall_cnt !== '1) begin
      errors++;
      $display("FAIL saturation: stall_cnt=%0d, expected %0d", stall_cnt, {CW{1'b1}});
    end
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    if (errors == 0) $display("PASS");
    else             $display("FAIL");
    $finish;
  end

endmodule
